// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the four-domain reset-release sequencer.
package rstseq_pkg;

  localparam int NDOM_DEF   = 4;
  localparam int CNTW_DEF   = 8;
  localparam int ACK_TO_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_WACK  = 3'd2,
    ST_DONE  = 3'd3,
    ST_SHOLD = 3'd4,
    ST_SWACK = 3'd5
  } state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] r;
    casez (v)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rstseq_cnt.sv
// Loadable down-counter with a terminal flag at cnt==1; load wins over decrement.
// Flag is combinational from the registered count, so it is valid one cycle after a load.
module rstseq_cnt #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic            term
);

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign term = (cnt == CNTW'(1));

endmodule

// File: rtl/rstseq04.sv
// Releases four reset domains in order 0..3 with a hold before each and an ack wait after,
// then serves soft-reset requests one domain at a time; all outputs registered.
module rstseq04
  import rstseq_pkg::*;
#(
  parameter int NDOM   = NDOM_DEF,
  parameter int CNTW   = CNTW_DEF,
  parameter int ACK_TO = ACK_TO_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] hold_cyc,
  input  logic [NDOM-1:0] dom_ack,
  input  logic [NDOM-1:0] sw_req,
  output logic [NDOM-1:0] dom_rst_req,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_dom
);

  localparam logic [1:0] LAST_DOM = 2'(NDOM - 1);

  state_t          state, state_n;
  logic [1:0]      idx, idx_n, pick;
  logic [NDOM-1:0] pend, pend_n, req_n, pick_mask;
  logic            err_n;
  logic [1:0]      err_dom_n;
  logic            cnt_load, cnt_dec, cnt_term;
  logic [CNTW-1:0] cnt_val, hold_val;

  assign hold_val  = (hold_cyc == '0) ? CNTW'(1) : hold_cyc;
  assign pick      = lowest_set(pend);
  assign pick_mask = NDOM'(1) << pick;

  // Hold and ack-timeout never overlap, so one counter serves both.
  rstseq_cnt #(.CNTW(CNTW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .term     (cnt_term)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pend_n    = (state == ST_IDLE) ? pend : (pend | sw_req);
    req_n     = dom_rst_req;
    err_n     = err;
    err_dom_n = err_dom;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = hold_val;

    case (state)
      ST_IDLE: begin
        req_n = '1;
        if (start) begin
          state_n  = ST_HOLD;
          idx_n    = 2'd0;
          err_n    = 1'b0;
          cnt_load = 1'b1;
        end
      end

      ST_HOLD, ST_SHOLD: begin
        cnt_dec = 1'b1;
        if (cnt_term) begin
          req_n[idx] = 1'b0;
          cnt_load   = 1'b1;
          cnt_val    = CNTW'(ACK_TO);
          state_n    = (state == ST_HOLD) ? ST_WACK : ST_SWACK;
        end
      end

      ST_WACK, ST_SWACK: begin
        cnt_dec = 1'b1;
        // Ack is checked before expiry so a same-cycle ack wins.
        if (dom_ack[idx]) begin
          if ((state == ST_SWACK) || (idx == LAST_DOM)) begin
            state_n = ST_DONE;
          end else begin
            idx_n    = idx + 2'd1;
            cnt_load = 1'b1;
            state_n  = ST_HOLD;
          end
        end else if (cnt_term) begin
          err_n     = 1'b1;
          err_dom_n = idx;
          req_n     = '1;
          state_n   = ST_IDLE;
        end
      end

      ST_DONE: begin
        req_n = '0;
        if (start) begin
          req_n    = '1;
          pend_n   = '0;
          idx_n    = 2'd0;
          err_n    = 1'b0;
          cnt_load = 1'b1;
          state_n  = ST_HOLD;
        end else if (pend != '0) begin
          // A new request for the picked domain in this cycle stays latched.
          req_n[pick] = 1'b1;
          pend_n      = (pend & ~pick_mask) | sw_req;
          idx_n       = pick;
          cnt_load    = 1'b1;
          state_n     = ST_SHOLD;
        end
      end

      default: begin
        req_n   = '1;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      pend        <= '0;
      dom_rst_req <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_dom     <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      pend        <= pend_n;
      dom_rst_req <= req_n;
      busy        <= state_n inside {ST_HOLD, ST_WACK, ST_SHOLD, ST_SWACK};
      done        <= state_n inside {ST_DONE, ST_SHOLD, ST_SWACK};
      err         <= err_n;
      err_dom     <= err_dom_n;
    end
  end

endmodule

// File: tb/tb_rstseq04.sv
// Scoreboarded bench for rstseq04: expected output changes are predicted from event
// arithmetic on each stimulus and popped by an independent monitor on every output change.
module tb_rstseq04;

  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] hold_cyc = 8'd0;
  logic [3:0] dom_ack = 4'h0;
  logic [3:0] sw_req = 4'h0;
  logic [3:0] dom_rst_req;
  logic       busy, done, err;
  logic [1:0] err_dom;

  rstseq04 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hold_cyc    (hold_cyc),
    .dom_ack     (dom_ack),
    .sw_req      (sw_req),
    .dom_rst_req (dom_rst_req),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_dom     (err_dom)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] edom;
  } snap_t;

  typedef struct {
    int    edge_n;
    snap_t s;
  } ev_t;

  ev_t   expq[$];
  snap_t mexp;
  snap_t last_s;
  snap_t cur_s;
  ev_t   got_e;
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    lat[4];
  bit    stuck[4];
  int    zcnt[4];
  bit    mon_en = 1'b0;
  string cur_test = "reset";

  localparam snap_t RST_SNAP = '{req: 4'hF, busy: 1'b0, done: 1'b0, err: 1'b0, edom: 2'd0};

  always @(posedge clk) cyc <= cyc + 1;

  // Domain model: ack rises once the domain has been out of reset for lat[d] cycles.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (dom_rst_req[d] !== 1'b0) zcnt[d] = 0;
      else zcnt[d] = zcnt[d] + 1;
      dom_ack[d] = (zcnt[d] >= lat[d]) && !stuck[d];
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      cur_s = {dom_rst_req, busy, done, err, err_dom};
      if (cur_s !== last_s) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL %s unexpected change cyc=%0d got=%b", cur_test, cyc, cur_s);
        end else begin
          got_e = expq.pop_front();
          if ((got_e.edge_n != cyc) || (got_e.s !== cur_s)) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%b(req,busy,done,err,edom) want=%b at cyc %0d",
                     cur_test, cyc, cur_s, got_e.s, got_e.edge_n);
          end
        end
        last_s = cur_s;
      end
    end
  end

  function automatic void push_ev(int e, snap_t s);
    ev_t x;
    if (s != mexp) begin
      x.edge_n = e;
      x.s      = s;
      expq.push_back(x);
      mexp = s;
    end
  endfunction

  // Full release sequence for a start sampled at edge t; returns the edge it settles.
  function automatic int model_full(int t, int h);
    snap_t s;
    int hh, r, prev;
    s  = mexp;
    hh = (h == 0) ? 1 : h;
    s.req = 4'hF; s.busy = 1'b1; s.done = 1'b0; s.err = 1'b0;
    push_ev(t, s);
    prev = t;
    for (int d = 0; d < 4; d++) begin
      r = prev + hh;
      s.req[d] = 1'b0;
      push_ev(r, s);
      if (stuck[d] || (lat[d] > TO)) begin
        s.req = 4'hF; s.busy = 1'b0; s.err = 1'b1; s.edom = 2'(d);
        push_ev(r + TO, s);
        return r + TO;
      end
      prev = r + lat[d];
    end
    s.busy = 1'b0; s.done = 1'b1;
    push_ev(prev, s);
    return prev;
  endfunction

  // Soft resets: mask m1 sampled at edge p1, m2 at edge p2 (during the first service).
  function automatic int model_soft(int h, int p1, logic [3:0] m1, int p2, logic [3:0] m2);
    snap_t      s;
    logic [3:0] pend;
    bit         m2_in;
    int         hh, now, sv, r, a, i;
    s     = mexp;
    pend  = m1;
    m2_in = (m2 == 4'h0);
    hh    = (h == 0) ? 1 : h;
    now   = p1;
    while (pend != 4'h0) begin
      i = 0;
      for (int k = 3; k >= 0; k--) if (pend[k]) i = k;
      pend[i] = 1'b0;
      sv = now + 1;
      s.req[i] = 1'b1; s.busy = 1'b1;
      push_ev(sv, s);
      r = sv + hh;
      s.req[i] = 1'b0;
      push_ev(r, s);
      if (stuck[i] || (lat[i] > TO)) begin
        s.req = 4'hF; s.busy = 1'b0; s.done = 1'b0; s.err = 1'b1; s.edom = 2'(i);
        push_ev(r + TO, s);
        return r + TO;
      end
      a = r + lat[i];
      s.busy = 1'b0;
      push_ev(a, s);
      if (!m2_in && (p2 <= a)) begin
        pend  = pend | m2;
        m2_in = 1'b1;
      end
      now = a;
    end
    return now;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((expq.size() != 0) && (b < 3000)) begin
      @(negedge clk);
      b++;
    end
    if (expq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s drain timeout: %0d expected changes never seen", cur_test, expq.size());
      expq.delete();
    end
    tick(4);
  endtask

  task automatic run_full(string name, bit extra_start);
    int t;
    cur_test = name;
    t = cyc + 1;
    void'(model_full(t, int'(hold_cyc)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (extra_start) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain();
  endtask

  task automatic run_soft(string name, logic [3:0] m1, logic [3:0] m2);
    int p1;
    cur_test = name;
    p1 = cyc + 1;
    void'(model_soft(int'(hold_cyc), p1, m1, p1 + 2, m2));
    sw_req = m1;
    @(negedge clk);
    sw_req = 4'h0;
    @(negedge clk);
    sw_req = m2;
    @(negedge clk);
    sw_req = 4'h0;
    wait_drain();
  endtask

  task automatic set_lat(int v);
    for (int d = 0; d < 4; d++) begin
      lat[d]   = v;
      stuck[d] = 1'b0;
    end
  endtask

  initial begin
    int kind, t, x;
    set_lat(2);
    rst = 1'b1;
    tick(3);
    cur_s = {dom_rst_req, busy, done, err, err_dom};
    vectors++;
    if (cur_s !== RST_SNAP) begin
      miscompares++;
      $display("FAIL reset_state got=%b want=%b", cur_s, RST_SNAP);
    end
    mexp   = RST_SNAP;
    last_s = RST_SNAP;
    rst    = 1'b0;
    mon_en = 1'b1;
    tick(2);

    hold_cyc = 8'd3;
    run_full("t1_seq_h3", 1'b0);

    run_soft("t4_soft_1010", 4'b1010, 4'b0000);
    set_lat(3);
    run_soft("soft_rerequest", 4'b0100, 4'b0101);

    hold_cyc = 8'd0;
    set_lat(1);
    run_full("t2_h0_restart", 1'b1);

    hold_cyc = 8'd2;
    set_lat(2);
    lat[1] = TO;
    run_full("t5_ack_at_expiry", 1'b0);

    cur_test = "ack_drop_in_done";
    stuck[0] = 1'b1;
    tick(12);
    stuck[0] = 1'b0;
    tick(6);

    for (int it = 0; it < 12; it++) begin
      kind     = $urandom_range(0, 2);
      hold_cyc = 8'($urandom_range(0, 5));
      for (int d = 0; d < 4; d++) begin
        lat[d]   = $urandom_range(1, 6);
        stuck[d] = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) lat[$urandom_range(0, 3)] = TO;
      if (kind == 0) run_full("rand_full", 1'b0);
      else run_soft("rand_soft", 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
    end

    hold_cyc = 8'd1;
    set_lat(2);
    stuck[2] = 1'b1;
    run_full("t3_timeout_dom2", 1'b0);
    stuck[2] = 1'b0;

    cur_test = "sw_in_idle";
    sw_req   = 4'b1001;
    @(negedge clk);
    sw_req = 4'h0;
    tick(4);

    lat[0] = TO + 1;
    run_full("timeout_dom0_256", 1'b0);
    set_lat(2);
    run_full("t3_restart_clears_err", 1'b0);
    tick(8);

    stuck[1] = 1'b1;
    run_soft("soft_timeout_dom1", 4'b0010, 4'b0000);
    set_lat(3);

    cur_test = "t6_rst_in_wack";
    hold_cyc = 8'd2;
    t = cyc + 1;
    void'(model_full(t, 2));
    x = t + 2 + 3 + 2 + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + 5) @(negedge clk);
    sw_req = 4'b0001;
    @(negedge clk);
    sw_req = 4'h0;
    while (cyc < x - 1) @(negedge clk);
    while ((expq.size() != 0) && (expq[expq.size() - 1].edge_n >= x)) void'(expq.pop_back());
    got_e.edge_n = x;
    got_e.s      = RST_SNAP;
    expq.push_back(got_e);
    mexp = RST_SNAP;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_drain();

    run_full("after_rst_full", 1'b0);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
